// File: rtl/mdu_if.sv
// Handshake and result bundle between the E-stage pipeline and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (output start, md_op, A, B, Req, input busy, hi, lo, md_out);
  modport slave  (input start, md_op, A, B, Req, output busy, hi, lo, md_out);
endinterface

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit owning HI/LO, with a fixed-latency busy window.
// Define MDU_MADD_EN to enable MADD/MADDU (md_op 9/10) accumulate into {HI,LO}.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [3:0]     op_reg;
  logic [31:0]    a_reg, b_reg, hi_reg, lo_reg;
  logic           accept, is_mul, is_div, launch, finish;

  assign bus.busy   = (state_reg == RUN);
  assign bus.hi     = hi_reg;
  assign bus.lo     = lo_reg;
  assign bus.md_out = (bus.md_op == OP_MFHI) ? hi_reg :
                      (bus.md_op == OP_MFLO) ? lo_reg : 32'd0;

  assign accept = bus.start & ~bus.Req & ~bus.busy;

  always_comb begin
    is_div = (bus.md_op == OP_DIV) || (bus.md_op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_mul = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU) ||
             (bus.md_op == OP_MADD) || (bus.md_op == OP_MADDU);
`else
    is_mul = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);
`endif
    launch = accept & (is_mul | is_div);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next = RUN;
          cnt_next   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Result datapath evaluated from the latched operands; sampled only at the finishing edge.
  logic        signed_op, div_op, res_we;
  logic [63:0] opa, opb, prod, res64;
  logic [31:0] ua, ub, uq, ur, res_hi, res_lo;

  always_comb begin
    signed_op = (op_reg == OP_MULT) || (op_reg == OP_DIV) || (op_reg == OP_MADD);
    div_op    = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
    opa  = signed_op ? {{32{a_reg[31]}}, a_reg} : {32'd0, a_reg};
    opb  = signed_op ? {{32{b_reg[31]}}, b_reg} : {32'd0, b_reg};
    prod = opa * opb;
`ifdef MDU_MADD_EN
    res64 = ((op_reg == OP_MADD) || (op_reg == OP_MADDU)) ? ({hi_reg, lo_reg} + prod) : prod;
`else
    res64 = prod;
`endif
    // Signed divide via magnitudes: quotient toward zero, remainder follows dividend.
    ua = (signed_op & a_reg[31]) ? (~a_reg + 32'd1) : a_reg;
    ub = (signed_op & b_reg[31]) ? (~b_reg + 32'd1) : b_reg;
    uq = (ub == 32'd0) ? 32'd0 : ua / ub;
    ur = (ub == 32'd0) ? 32'd0 : ua % ub;
    if (div_op) begin
      res_lo = (signed_op & (a_reg[31] ^ b_reg[31])) ? (~uq + 32'd1) : uq;
      res_hi = (signed_op & a_reg[31]) ? (~ur + 32'd1) : ur;
      res_we = (b_reg != 32'd0);
    end else begin
      res_lo = res64[31:0];
      res_hi = res64[63:32];
      res_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg <= 4'd0;
      a_reg  <= 32'd0;
      b_reg  <= 32'd0;
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else begin
      if (launch) begin
        op_reg <= bus.md_op;
        a_reg  <= bus.A;
        b_reg  <= bus.B;
      end
      if (finish && res_we) begin
        hi_reg <= res_hi;
        lo_reg <= res_lo;
      end else if (accept && bus.md_op == OP_MTHI) begin
        hi_reg <= bus.A;
      end else if (accept && bus.md_op == OP_MTLO) begin
        lo_reg <= bus.A;
      end
    end
  end
endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed vector table, hand sequences, and a
// randomized lockstep comparison against a cycle-level arithmetic reference model.
module tb_mdu_e;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mdu_if mif();

  mdu_e dut (.clk(clk), .reset(reset), .bus(mif));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]  m_op;
  bit          m_pend;
  int          m_due, edge_n;

  // Values sampled at the most recent negedge
  logic        s_busy;
  logic [31:0] s_hi, s_lo;

  function automatic bit ref_launch_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || op == 4'd9 || op == 4'd10;
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  task automatic ref_complete();
    logic [63:0] p;
    int sa, sb, q, r;
    case (m_op)
      4'd1, 4'd9:  p = 64'(longint'($signed(m_a)) * longint'($signed(m_b)));
      4'd2, 4'd10: p = 64'(m_a) * 64'(m_b);
      default:     p = 64'd0;
    endcase
    case (m_op)
      4'd1, 4'd2: {m_hi, m_lo} = p;
      4'd9, 4'd10: {m_hi, m_lo} = {m_hi, m_lo} + p;
      4'd3: begin
        sa = m_a; sb = m_b;
        if (sb != 0) begin
          if (sa == 32'h80000000 && sb == -1) begin q = sa; r = 0; end
          else begin q = sa / sb; r = sa % sb; end
          m_lo = q; m_hi = r;
        end
      end
      4'd4: if (m_b != 0) begin m_lo = m_a / m_b; m_hi = m_a % m_b; end
      default: ;
    endcase
  endtask

  task automatic ref_edge(input bit st, input logic [3:0] op, input logic [31:0] a,
                          input bit rq, input bit rst, input logic [31:0] b);
    edge_n++;
    if (rst) begin
      m_pend = 0; m_hi = 0; m_lo = 0;
    end else if (m_pend) begin
      if (edge_n == m_due) begin ref_complete(); m_pend = 0; end
    end else if (st && !rq) begin
      if (ref_launch_op(op)) begin
        m_pend = 1; m_op = op; m_a = a; m_b = b;
        m_due = edge_n + ((op == 4'd3 || op == 4'd4) ? 10 : 5);
      end else if (op == 4'd7) m_hi = a;
      else if (op == 4'd8) m_lo = a;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive, compare against model at negedge, advance model at posedge.
  task automatic step(input bit st, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit rq, input bit rst);
    logic [31:0] exp_mdo;
    mif.start = st; mif.md_op = op; mif.A = a; mif.B = b; mif.Req = rq; reset = rst;
    @(negedge clk);
    s_busy = mif.busy; s_hi = mif.hi; s_lo = mif.lo;
    exp_mdo = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    tests++;
    if (mif.busy !== m_pend || mif.hi !== m_hi || mif.lo !== m_lo || mif.md_out !== exp_mdo) begin
      fails++;
      $display("FAIL lockstep t=%0t: busy/hi/lo/md_out got %b %h %h %h expected %b %h %h %h",
               $time, mif.busy, mif.hi, mif.lo, mif.md_out, m_pend, m_hi, m_lo, exp_mdo);
    end
    @(posedge clk);
    ref_edge(st, op, a, rq, rst, b);
    #1;
  endtask

  task automatic run_idle(input int n, output int bc);
    bc = 0;
    for (int i = 0; i < n; i++) begin
      step(0, 4'd0, 32'd0, 32'd0, 0, 0);
      bc += int'(s_busy);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vt[$];

  initial begin
    int bc, tot;
    logic [3:0] rop;
    logic [31:0] ra, rb;

    vt.push_back('{4'd1, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    vt.push_back('{4'd3, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vt.push_back('{4'd4, 32'd55, 32'd0, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 10});
    vt.push_back('{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5});
    vt.push_back('{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h00000000, 32'h80000000, 10});
    vt.push_back('{4'd3, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10});
    vt.push_back('{4'd4, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'h00000001, 32'h7FFFFFFC, 10});
    vt.push_back('{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h3FFFFFFF, 32'h00000001, 5});
    vt.push_back('{4'd11, 32'd9, 32'd9, 32'hA, 32'hB, 32'hA, 32'hB, 0});
`ifdef MDU_MADD_EN
    vt.push_back('{4'd10, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5});
    vt.push_back('{4'd9, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h5, 32'h00000000, 32'h00000003, 5});
`else
    vt.push_back('{4'd10, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0});
    vt.push_back('{4'd9, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h5, 32'h00000000, 32'h00000005, 0});
`endif

    mif.start = 0; mif.md_op = 0; mif.A = 0; mif.B = 0; mif.Req = 0;
    repeat (2) @(posedge clk);
    #1;
    m_hi = 0; m_lo = 0; m_pend = 0; m_due = 0; edge_n = 0; m_op = 0; m_a = 0; m_b = 0;

    step(0, 4'd0, 32'd0, 32'd0, 0, 0);
    check("reset_busy", {31'd0, s_busy}, 32'd0);
    check("reset_hi", s_hi, 32'd0);
    check("reset_lo", s_lo, 32'd0);

    foreach (vt[i]) begin
      step(1, 4'd7, vt[i].pre_hi, 32'd0, 0, 0);
      step(1, 4'd8, vt[i].pre_lo, 32'd0, 0, 0);
      step(1, vt[i].op, vt[i].a, vt[i].b, 0, 0);
      run_idle(14, bc);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vt[i].exp_busy));
      check($sformatf("vec%0d_hi", i), s_hi, vt[i].exp_hi);
      check($sformatf("vec%0d_lo", i), s_lo, vt[i].exp_lo);
      $display("[TB] vec%0d op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d", i, vt[i].op,
               vt[i].a, vt[i].b, s_hi, s_lo, bc);
    end

    // MTLO blocked by Req, then accepted
    step(1, 4'd8, 32'd0, 32'd0, 0, 0);
    step(1, 4'd8, 32'h12345678, 32'd0, 1, 0);
    step(0, 4'd0, 32'd0, 32'd0, 0, 0);
    check("mtlo_req_lo", s_lo, 32'd0);
    step(1, 4'd8, 32'h12345678, 32'd0, 0, 0);
    step(0, 4'd0, 32'd0, 32'd0, 0, 0);
    check("mtlo_lo", s_lo, 32'h12345678);
    check("mtlo_busy", {31'd0, s_busy}, 32'd0);

    // MULTU with a second start while busy and Req during cycle 3
    step(1, 4'd2, 32'd3, 32'd5, 0, 0);
    step(0, 4'd0, 32'd0, 32'd0, 0, 0);      tot = int'(s_busy);
    step(1, 4'd1, 32'd9, 32'd9, 0, 0);      tot += int'(s_busy);
    step(1, 4'd7, 32'hDEAD, 32'd0, 1, 0);   tot += int'(s_busy);
    run_idle(8, bc);
    check("multu_req_busy", 32'(tot + bc), 32'd5);
    check("multu_req_hi", s_hi, 32'd0);
    check("multu_req_lo", s_lo, 32'd15);

    // Reset in the middle of a DIV, then a fresh MULT
    step(1, 4'd3, 32'd100, 32'd7, 0, 0);
    run_idle(3, bc);
    step(0, 4'd0, 32'd0, 32'd0, 0, 1);
    step(0, 4'd0, 32'd0, 32'd0, 0, 0);
    check("rst_mid_busy", {31'd0, s_busy}, 32'd0);
    check("rst_mid_hi", s_hi, 32'd0);
    check("rst_mid_lo", s_lo, 32'd0);
    step(1, 4'd1, 32'd6, 32'd7, 0, 0);
    run_idle(8, bc);
    check("post_rst_busy", 32'(bc), 32'd5);
    check("post_rst_lo", s_lo, 32'd42);

    // Randomized lockstep against the reference model
    for (int i = 0; i < 3000; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      step($urandom_range(0, 2) != 0, rop, ra, rb, $urandom_range(0, 3) == 0,
           $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
